// File: rtl/kpscan.sv
// Keypad scanner: walks one low column at a time, samples synchronised active-low rows,
// debounces press and release, and emits a key code with press/release/auto-repeat strobes.
module kpscan #(
  parameter int unsigned ROWS          = 4,
  parameter int unsigned COLS          = 4,
  parameter int unsigned SCAN_DIV      = 1000,
  parameter int unsigned DEBOUNCE      = 8,
  parameter int unsigned REPEAT_DELAY  = 250,
  parameter int unsigned REPEAT_PERIOD = 50,
  localparam int unsigned CODE_W       = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ROWS-1:0]   kpr,
  input  logic              repeat_en,
  output logic [COLS-1:0]   kpc,
  output logic              kphit,
  output logic [CODE_W-1:0] num,
  output logic              press,
  output logic              key_release
);

  localparam int unsigned ColW   = $clog2(COLS);
  localparam int unsigned RowW   = $clog2(ROWS);
  localparam int unsigned DivW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW   = $clog2(DEBOUNCE + 1);
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  typedef enum logic [1:0] {StScan, StConfirm, StHeld} state_e;

  state_e              state_q, state_d;
  logic [ROWS-1:0]     sync1_q, sync2_q;
  logic [DivW-1:0]     div_q, div_d;
  logic [ColW-1:0]     col_q, col_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [RepW-1:0]     hold_q, hold_d;
  logic                first_q, first_d;
  logic                kphit_q, kphit_d;
  logic [CODE_W-1:0]   num_q, num_d;
  logic                press_q, press_d;
  logic                release_q, release_d;

  logic                sample, hit_valid, key_down, accept, rep_due;
  logic [RowW-1:0]     hit_row;
  logic [ColW-1:0]     col_next;
  logic [CntW-1:0]     cnt_inc;
  logic [RepW-1:0]     hold_inc, rep_limit;
  int unsigned         n_low;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StScan;
      sync1_q   <= '1;
      sync2_q   <= '1;
      div_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      first_q   <= 1'b1;
      kphit_q   <= 1'b0;
      num_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= kpr;
      sync2_q   <= sync1_q;
      div_q     <= div_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      first_q   <= first_d;
      kphit_q   <= kphit_d;
      num_q     <= num_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Exactly one low row is a valid hit; several low rows are ambiguous and read as no key.
  always_comb begin
    n_low   = 0;
    hit_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!sync2_q[r]) begin
        n_low   = n_low + 1;
        hit_row = RowW'(r);
      end
    end
    hit_valid = (n_low == 1);
  end

  always_comb begin
    sample    = (div_q == DivW'(SCAN_DIV - 1));
    key_down  = hit_valid && (hit_row == row_q);
    col_next  = (col_q == ColW'(COLS - 1)) ? '0 : col_q + ColW'(1);
    cnt_inc   = cnt_q + CntW'(1);
    hold_inc  = hold_q + RepW'(1);
    rep_limit = first_q ? RepW'(REPEAT_DELAY) : RepW'(REPEAT_PERIOD);
    rep_due   = 1'b0;
    accept    = 1'b0;

    state_d   = state_q;
    div_d     = sample ? '0 : div_q + DivW'(1);
    col_d     = col_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    first_d   = first_q;
    kphit_d   = kphit_q;
    num_d     = num_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    if (sample) begin
      unique case (state_q)
        StScan: begin
          if (hit_valid) begin
            row_d = hit_row;
            if (DEBOUNCE == 1) begin
              accept = 1'b1;
            end else begin
              state_d = StConfirm;
              cnt_d   = CntW'(1);
            end
          end else begin
            col_d = col_next;
          end
        end
        StConfirm: begin
          if (key_down) begin
            if (cnt_inc == CntW'(DEBOUNCE)) accept = 1'b1;
            else                            cnt_d  = cnt_inc;
          end else begin
            state_d = StScan;
            cnt_d   = '0;
            col_d   = col_next;
          end
        end
        StHeld: begin
          // Hold counter runs regardless of repeat_en; repeat_en only gates the strobe.
          if (hold_inc == rep_limit) begin
            hold_d  = '0;
            first_d = 1'b0;
            rep_due = 1'b1;
          end else begin
            hold_d = hold_inc;
          end
          if (key_down) begin
            cnt_d   = '0;
            press_d = rep_due && repeat_en;
          end else if (cnt_inc == CntW'(DEBOUNCE)) begin
            state_d   = StScan;
            cnt_d     = '0;
            kphit_d   = 1'b0;
            release_d = 1'b1;
            col_d     = col_next;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = StScan;
      endcase
    end

    if (accept) begin
      state_d = StHeld;
      cnt_d   = '0;
      hold_d  = '0;
      first_d = 1'b1;
      kphit_d = 1'b1;
      press_d = 1'b1;
      num_d   = CODE_W'(int'(col_q) * int'(ROWS) + int'(hit_row));
    end
  end

  always_comb begin
    kpc         = '1;
    kpc[col_q]  = 1'b0;
    kphit       = kphit_q;
    num         = num_q;
    press       = press_q;
    key_release = release_q;
  end

endmodule

// File: tb/tb_kpscan.sv
// Bench for kpscan: keypad matrix model, strobe scoreboard, table-driven key sessions
// and hand-written bounce, partial-release, ambiguous and reset sequences.
module tb_kpscan;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       repeat_en = 1'b0;
  logic [3:0] kpr, kpc, num;
  logic       kphit, press, key_release;
  logic [15:0] keys = '0;
  int         tb_div;
  int         checks = 0;
  int         failures = 0;

  typedef struct { bit is_press; logic [3:0] num; bit hit; } ev_t;
  ev_t sb[$];

  typedef struct {
    int         code;
    bit         rep;
    int         hold;
    logic [3:0] exp_num;
    logic [3:0] exp_kpc;
    int         exp_reps;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  kpscan #(
    .ROWS(4), .COLS(4), .SCAN_DIV(SD), .DEBOUNCE(3), .REPEAT_DELAY(5), .REPEAT_PERIOD(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .kpr(kpr), .repeat_en(repeat_en), .kpc(kpc),
    .kphit(kphit), .num(num), .press(press), .key_release(key_release)
  );

  // Key at code c*4+r pulls row r low while column c is driven low.
  always_comb begin
    kpr = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !kpc[c]) kpr[r] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) tb_div <= 0;
    else          tb_div <= (tb_div == SD - 1) ? 0 : tb_div + 1;

  always @(negedge clk) begin : mon
    ev_t e;
    if (reset_n && (press || key_release)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe press=%0b release=%0b num=%0d", press, key_release, num);
      end else begin
        e = sb.pop_front();
        if (e.is_press != press || e.is_press == key_release || e.num != num || e.hit != kphit) begin
          failures++;
          $display("FAIL strobe actual press=%0b release=%0b num=%0d kphit=%0b required press=%0b num=%0d kphit=%0b",
                   press, key_release, num, kphit, e.is_press, e.num, e.hit);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit is_press, input logic [3:0] n, input bit hit);
    ev_t e;
    e.is_press = is_press;
    e.num = n;
    e.hit = hit;
    sb.push_back(e);
  endtask

  // Returns 1 time unit after the next sampling edge.
  task automatic next_sample();
    do @(negedge clk); while (tb_div != SD - 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_col(input logic [3:0] want);
    int n = 0;
    do begin @(negedge clk); n++; end while (kpc != want && n < 200);
    chk("wait_col", kpc, want);
  endtask

  initial begin
    logic [3:0] exp_kpc;
    logic [3:0] seen;
    tbl[0] = '{code: 9,  rep: 1'b0, hold: 3,  exp_num: 4'd9,  exp_kpc: 4'b1011, exp_reps: 0};
    tbl[1] = '{code: 4,  rep: 1'b1, hold: 12, exp_num: 4'd4,  exp_kpc: 4'b1101, exp_reps: 4};
    tbl[2] = '{code: 15, rep: 1'b0, hold: 12, exp_num: 4'd15, exp_kpc: 4'b0111, exp_reps: 0};
    tbl[3] = '{code: 0,  rep: 1'b1, hold: 6,  exp_num: 4'd0,  exp_kpc: 4'b1110, exp_reps: 1};
    tbl[4] = '{code: 6,  rep: 1'b1, hold: 7,  exp_num: 4'd6,  exp_kpc: 4'b1101, exp_reps: 2};

    repeat (2) @(negedge clk);
    chk("rst_kpc", kpc, 4'b1110);
    chk("rst_kphit", kphit, 0);
    chk("rst_num", num, 0);
    chk("rst_press", press, 0);
    chk("rst_release", key_release, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      exp_kpc = ~(4'b0001 << (((i + 1) / 4) % 4));
      chk("idle_kpc", kpc, exp_kpc);
    end
    chk("idle_kphit", kphit, 0);
    chk("idle_num", num, 0);

    // Bounce on code 9: one low sample, one high, then stable low.
    wait_col(4'b1011);
    keys[9] = 1'b1;
    next_sample();
    keys[9] = 1'b0;
    next_sample();
    chk("bounce_abort_kphit", kphit, 0);
    keys[9] = 1'b1;
    push(1'b1, 4'd9, 1'b1);
    wait_drain(200, "bounce_press");
    chk("bounce_kpc", kpc, 4'b1011);
    chk("bounce_num", num, 9);

    // Partial release: high, high, low, high, high, high.
    keys[9] = 1'b0;
    next_sample();
    next_sample();
    chk("partial_kphit", kphit, 1);
    keys[9] = 1'b1;
    next_sample();
    keys[9] = 1'b0;
    next_sample();
    next_sample();
    chk("partial_kphit2", kphit, 1);
    push(1'b0, 4'd9, 1'b0);
    next_sample();
    chk("release_now", key_release, 1);
    wait_drain(4, "partial_release");
    chk("release_num", num, 9);

    for (int t = 0; t < 5; t++) begin
      repeat_en = tbl[t].rep;
      push(1'b1, tbl[t].exp_num, 1'b1);
      keys[tbl[t].code] = 1'b1;
      wait_drain(200, "tbl_press");
      chk("tbl_kpc", kpc, tbl[t].exp_kpc);
      chk("tbl_num", num, tbl[t].exp_num);
      for (int j = 0; j < tbl[t].exp_reps; j++) push(1'b1, tbl[t].exp_num, 1'b1);
      for (int k = 0; k < tbl[t].hold; k++) next_sample();
      wait_drain(4, "tbl_repeats");
      chk("tbl_hold_kpc", kpc, tbl[t].exp_kpc);
      repeat_en = 1'b0;
      keys = '0;
      push(1'b0, tbl[t].exp_num, 1'b0);
      wait_drain(200, "tbl_release");
      chk("tbl_rel_kphit", kphit, 0);
      chk("tbl_rel_num", num, tbl[t].exp_num);
    end

    // Rows 0 and 2 together on column 0 are ambiguous; scanning must continue.
    keys[0] = 1'b1;
    keys[2] = 1'b1;
    seen = '0;
    for (int k = 0; k < 10; k++) begin
      next_sample();
      seen = seen | ~kpc;
    end
    chk("ambig_kphit", kphit, 0);
    chk("ambig_scan", seen, 4'hf);
    keys = '0;

    // Exact press latency on code 5, then asynchronous reset while held.
    wait_col(4'b1101);
    keys[5] = 1'b1;
    next_sample();
    next_sample();
    chk("latency_not_yet", press, 0);
    push(1'b1, 4'd5, 1'b1);
    next_sample();
    chk("latency_press", press, 1);
    wait_drain(4, "latency");
    next_sample();
    next_sample();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_kphit", kphit, 0);
    chk("arst_kpc", kpc, 4'b1110);
    chk("arst_num", num, 0);
    chk("arst_release", key_release, 0);
    keys = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) next_sample();
    chk("post_rst_kphit", kphit, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
